// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Time-setting controller for a 24-hour digital clock. MODE walks the user
// through hours -> minutes -> seconds -> commit. UP/DOWN step the active field,
// with press-edge stepping plus auto-repeat while the key is held. While
// editing, the timekeeper is frozen (o_pause). The edited time is handed over
// with a single-cycle o_load strobe.
//
// Optional feature (compile-time macro SET_TIMEOUT_EN):
//   defined   - an idle counter abandons set mode after TIMEOUT idle ticks,
//               returning to RUN without a load.
//   undefined - set mode persists until the user commits.
//
// Parameters:
//   REPEAT_DELAY  ticks a held UP/DOWN must stay low before auto-repeat starts
//   REPEAT_PERIOD ticks between auto-repeat steps
//   BLINK_HALF    ticks per blink half-period
//   TIMEOUT       idle ticks before set mode is abandoned (SET_TIMEOUT_EN)
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_tick                          one-cycle 1 kHz pulse
//   i_key_mode/i_key_up/i_key_down  debounced keys, low = pressed
//   i_hh, i_mm, i_ss                running time from the timekeeper
//   o_pause                         high while editing (SET_x and COMMIT)
//   o_load                          one-cycle commit strobe
//   o_hh, o_mm, o_ss                edit registers
//   o_blink                         {hh,mm,ss} blank mask for the display
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter int unsigned BLINK_HALF    = 250,
  parameter int unsigned TIMEOUT       = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_key_mode,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic [4:0] i_hh,
  input  logic [5:0] i_mm,
  input  logic [5:0] i_ss,
  output logic       o_pause,
  output logic       o_load,
  output logic [4:0] o_hh,
  output logic [5:0] o_mm,
  output logic [5:0] o_ss,
  output logic [2:0] o_blink
);

  // One width for every tick counter keeps the terminal-count compares uniform.
  localparam int unsigned MAX_RP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned MAX_BT  = (BLINK_HALF > TIMEOUT) ? BLINK_HALF : TIMEOUT;
  localparam int unsigned MAX_ALL = (MAX_RP > MAX_BT) ? MAX_RP : MAX_BT;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {RUN, SET_HH, SET_MM, SET_SS, COMMIT} state_t;

  state_t             state;
  logic [2:0]         key_q;      // {mode, up, down} sampled levels
  logic [2:0]         key_prev;   // previous sampled levels
  logic [2:0]         press;
  logic               mode_ev, up_ev, dn_ev, any_ev;
  logic               up_held, dn_held, both_held, in_set;
  logic               rep_active, rep_up, rep_fast;
  logic [CNT_W-1:0]   rep_cnt, rep_limit;
  logic               rep_key_held;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_phase, phase_nxt;
  logic               step_req, step_up;
  logic               timeout_hit;

  // Wrap-around step with compare-and-reset arithmetic.
  function automatic logic [5:0] step_field(input logic [5:0] val,
                                            input logic [5:0] max_val,
                                            input logic       up);
    if (up) return (val == max_val) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0)    ? max_val : val - 6'd1;
  endfunction

  function automatic logic [2:0] field_mask(input state_t s);
    case (s)
      SET_HH:  return 3'b100;
      SET_MM:  return 3'b010;
      SET_SS:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Events are taken from the registered copy, so a key change sampled on one
  // edge acts on the following edge.
  assign press        = key_prev & ~key_q;
  assign mode_ev      = press[2];
  assign up_ev        = press[1];
  assign dn_ev        = press[0];
  assign any_ev       = |press;
  assign up_held      = ~key_q[1];
  assign dn_held      = ~key_q[0];
  assign both_held    = up_held & dn_held;
  assign in_set       = (state == SET_HH) || (state == SET_MM) || (state == SET_SS);
  assign rep_limit    = rep_fast ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
  assign rep_key_held = rep_up ? up_held : dn_held;

  // Blink phase after this edge; any key event forces "visible".
  assign phase_nxt = any_ev ? 1'b0
                   : blink_phase ^ (i_tick && (blink_cnt == CNT_W'(BLINK_HALF - 1)));

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    step_req = 1'b0;
    step_up  = 1'b0;
    if (both_held) begin
      step_req = 1'b0;
    end else if (up_ev || dn_ev) begin
      step_req = 1'b1;
      step_up  = up_ev;
    end else if (rep_active && rep_key_held && i_tick && (rep_cnt == rep_limit)) begin
      step_req = 1'b1;
      step_up  = rep_up;
    end
  end

`ifdef SET_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;

  assign timeout_hit = in_set && !any_ev && i_tick && (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                idle_cnt <= '0;
    else if (!in_set || any_ev)  idle_cnt <= '0;
    else if (i_tick)             idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every register, edit fields included, has a defined reset value;
    // there is no storage array here that could be left unreset.
    if (!i_rst_n) begin
      state       <= RUN;
      key_q       <= 3'b111;
      key_prev    <= 3'b111;
      rep_active  <= 1'b0;
      rep_up      <= 1'b0;
      rep_fast    <= 1'b0;
      rep_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      o_pause     <= 1'b0;
      o_load      <= 1'b0;
      o_blink     <= 3'b000;
      o_hh        <= '0;
      o_mm        <= '0;
      o_ss        <= '0;
    end else begin
      key_q    <= {i_key_mode, i_key_up, i_key_down};
      key_prev <= key_q;

      // Blink counter: free-running on ticks, restarted by any key event.
      blink_phase <= phase_nxt;
      if (any_ev)
        blink_cnt <= '0;
      else if (i_tick)
        blink_cnt <= (blink_cnt == CNT_W'(BLINK_HALF - 1)) ? '0 : blink_cnt + 1'b1;

      // Auto-repeat engine: armed only by a press edge inside a SET state, so
      // a key already held when a state is entered never repeats.
      if (!in_set || mode_ev || both_held || (rep_active && !rep_key_held)) begin
        rep_active <= 1'b0;
        rep_fast   <= 1'b0;
        rep_cnt    <= '0;
      end else if (up_ev || dn_ev) begin
        rep_active <= 1'b1;
        rep_up     <= up_ev;
        rep_fast   <= 1'b0;
        rep_cnt    <= '0;
      end else if (rep_active && i_tick) begin
        if (rep_cnt == rep_limit) begin
          rep_cnt  <= '0;
          rep_fast <= 1'b1;
        end else begin
          rep_cnt  <= rep_cnt + 1'b1;
        end
      end

      o_load  <= 1'b0;
      o_blink <= 3'b000;
      case (state)
        RUN: begin
          if (mode_ev) begin
            o_hh    <= i_hh;
            o_mm    <= i_mm;
            o_ss    <= i_ss;
            o_pause <= 1'b1;
            state   <= SET_HH;
          end
        end
        SET_HH, SET_MM, SET_SS: begin
          if (mode_ev) begin
            // MODE wins over UP/DOWN: the field is left untouched.
            if (state == SET_HH)      state <= SET_MM;
            else if (state == SET_MM) state <= SET_SS;
            else begin
              state  <= COMMIT;
              o_load <= 1'b1;
            end
          end else if (timeout_hit) begin
            state   <= RUN;
            o_pause <= 1'b0;
          end else begin
            o_blink <= phase_nxt ? field_mask(state) : 3'b000;
            if (step_req) begin
              case (state)
                SET_HH:  o_hh <= 5'(step_field({1'b0, o_hh}, 6'd23, step_up));
                SET_MM:  o_mm <= step_field(o_mm, 6'd59, step_up);
                default: o_ss <= step_field(o_ss, 6'd59, step_up);
              endcase
            end
          end
        end
        COMMIT: begin
          state   <= RUN;
          o_pause <= 1'b0;
        end
        default: begin
          state   <= RUN;
          o_pause <= 1'b0;
        end
      endcase
    end
  end

endmodule
